// File: rtl/pwm_capture.sv
// pwm_capture: receive side of the PWM link. Measures the period and high time of
// the incoming waveform in enable ticks, and reports the generator duty code once
// per period. A line with no rising edge for 2*CTRVAL ticks reports a stuck result.
module pwm_capture #(
  parameter int CTRVAL = 256,
  parameter int CTRLEN = $clog2(CTRVAL),
  parameter int CNTW   = $clog2(2*CTRVAL)+1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_pwm_in,
  output logic [CTRLEN-1:0] o_duty_cycle,
  output logic [CNTW-1:0]   o_period,
  output logic              o_valid,
  output logic              o_stuck,
  output logic              o_period_err,
  output logic              o_locked
);

  typedef enum logic {S_IDLE = 1'b0, S_MEASURE = 1'b1} state_t;

  localparam logic [CNTW-1:0] PER_NOM  = CNTW'(CTRVAL);
  localparam logic [CNTW-1:0] PER_TMO  = CNTW'(2*CTRVAL);
  // Tick count that, incremented once more, reaches the timeout length.
  localparam logic [CNTW-1:0] TMO_LAST = CNTW'(2*CTRVAL-1);
  localparam logic [CNTW-1:0] DUTY_MAX = CNTW'((2**CTRLEN)-1);
  localparam logic [CNTW-1:0] ONE      = CNTW'(1);

  logic [1:0]        r_sync;
  logic              r_samp;
  logic              r_prev;
  logic [CNTW-1:0]   r_per_cnt;
  logic [CNTW-1:0]   r_hi_cnt;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_rise;
  logic              w_tmo;
  logic [CNTW-1:0]   w_per_inc;
  logic [CNTW-1:0]   w_hi_inc;
  logic [CNTW-1:0]   w_hi_m1;
  logic [CTRLEN-1:0] w_duty_dec;

  // Synchronizer runs every clk; the sample pair advances only on enable ticks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_samp <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pwm_in};
      if (i_enable) begin
        r_samp <= r_sync[1];
        r_prev <= r_samp;
      end
    end
  end

  // Edge/timeout detection, saturating increments and duty decode.
  always_comb begin
    w_rise    = i_enable & r_samp & ~r_prev;
    // A rise on the same tick takes priority over the timeout.
    w_tmo     = i_enable & ~w_rise & (r_per_cnt >= TMO_LAST);
    w_per_inc = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + ONE;
    w_hi_inc  = (r_hi_cnt == '1) ? r_hi_cnt : r_hi_cnt + ONE;
    w_hi_m1   = r_hi_cnt - ONE;
    // Generator duty d produces d+1 high ticks, so decode is hi_cnt-1.
    if (r_hi_cnt == '0)
      w_duty_dec = '0;
    else if (w_hi_m1 >= DUTY_MAX)
      w_duty_dec = '1;
    else
      w_duty_dec = w_hi_m1[CTRLEN-1:0];
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: any rise locks on, a timeout drops back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (w_rise)     w_state_nxt = S_MEASURE;
    else if (w_tmo) w_state_nxt = S_IDLE;
  end

  // Period and high-time counters; frozen on non-enable clks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else if (i_enable) begin
      if (w_rise) begin
        // The rise tick is already the first high tick of the new period.
        r_per_cnt <= ONE;
        r_hi_cnt  <= ONE;
      end else if (w_tmo) begin
        r_per_cnt <= '0;
        r_hi_cnt  <= '0;
      end else begin
        r_per_cnt <= w_per_inc;
        if (r_samp) r_hi_cnt <= w_hi_inc;
      end
    end
  end

  // Result registers; hold between valid pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_duty_cycle <= '0;
      o_period     <= '0;
      o_stuck      <= 1'b0;
      o_period_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (w_rise && r_state == S_MEASURE) begin
        o_valid      <= 1'b1;
        o_duty_cycle <= w_duty_dec;
        o_period     <= r_per_cnt;
        o_stuck      <= 1'b0;
        o_period_err <= (r_per_cnt != PER_NOM);
      end else if (w_tmo) begin
        o_valid      <= 1'b1;
        o_duty_cycle <= r_samp ? '1 : '0;
        o_period     <= PER_TMO;
        o_stuck      <= 1'b1;
        o_period_err <= 1'b1;
      end
    end
  end

  assign o_locked = (r_state == S_MEASURE);

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture at CTRVAL=16: table of generator waveforms, hand-written
// stuck/reset/strobed-enable sequences, and random waveforms against a window model.
module tb_pwm_capture;
  localparam int CTRVAL = 16;
  localparam int CTRLEN = 4;
  localparam int CNTW   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic              pwm = 1'b0;
  logic [CTRLEN-1:0] duty;
  logic [CNTW-1:0]   per;
  logic              vld, stuck, perr, lock;

  pwm_capture #(.CTRVAL(CTRVAL)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_pwm_in(pwm),
    .o_duty_cycle(duty), .o_period(per), .o_valid(vld),
    .o_stuck(stuck), .o_period_err(perr), .o_locked(lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t; int duty; int per; int stuck; int err; int lock; int en_prev;
  } ev_t;

  typedef struct {
    int per; int hi; int e_duty; int e_per; int e_err;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   tick_no = 0;
  logic last_en = 1'b0;
  ev_t  evq[$];
  vec_t tbl[$];
  bit   pq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clk: drive inputs after the edge, observe outputs on the falling edge.
  task automatic step(input logic p, input logic e, input logic r);
    @(posedge clk); #1;
    last_en = en;
    pwm = p; en = e; rst = r;
    @(negedge clk);
    tick_no++;
    if (vld === 1'b1)
      evq.push_back('{tick_no, int'(duty), int'(per), int'(stuck), int'(perr),
                      int'(lock), int'(last_en)});
  endtask

  // After this, the next step() is tick 0 (first clk with reset released).
  task automatic do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b1);
    tick_no = -1;
    evq.delete();
  endtask

  task automatic run_wave(input int p, input int h, input int nper, input int tail);
    for (int n = 0; n < nper; n++)
      for (int t = 0; t < p; t++) step(t < h, 1'b1, 1'b0);
    for (int t = 0; t < tail; t++) step(t < h, 1'b1, 1'b0);
  endtask

  // Sampled level seen on tick k: pwm driven on tick k-3, zero before that.
  function automatic bit samp_at(input int k);
    return (k >= 3) ? pq[k-3] : 1'b0;
  endfunction

  initial begin
    // ---------------- reset state ----------------
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_valid", vld, 0);
    chk("rst_duty", duty, 0);
    chk("rst_period", per, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_perr", perr, 0);
    chk("rst_locked", lock, 0);

    // ---------------- table: generator duty sweep + off-nominal square ----------------
    for (int d = 1; d <= 14; d++) tbl.push_back('{16, d+1, d, 16, 0});
    tbl.push_back('{16, 9, 8, 16, 0});
    tbl.push_back('{12, 6, 5, 12, 1});
    tbl.push_back('{20, 20-1, 15, 20, 1});
    foreach (tbl[i]) begin
      do_reset();
      run_wave(tbl[i].per, tbl[i].hi, 3, 5);
      chk($sformatf("tbl%0d_count", i), evq.size(), 3);
      foreach (evq[k]) begin
        chk($sformatf("tbl%0d_duty", i), evq[k].duty, tbl[i].e_duty);
        chk($sformatf("tbl%0d_period", i), evq[k].per, tbl[i].e_per);
        chk($sformatf("tbl%0d_perr", i), evq[k].err, tbl[i].e_err);
        chk($sformatf("tbl%0d_stuck", i), evq[k].stuck, 0);
        chk($sformatf("tbl%0d_locked", i), evq[k].lock, 1);
        if (k > 0) chk($sformatf("tbl%0d_spacing", i), evq[k].t - evq[k-1].t, tbl[i].per);
      end
    end

    // ---------------- stuck high: rise arms at tick 3, timeouts 32 ticks apart ----------------
    do_reset();
    repeat (100) step(1'b1, 1'b1, 1'b0);
    chk("hi_count", evq.size(), 3);
    foreach (evq[k]) begin
      chk("hi_tick", evq[k].t, 35 + 32*k);
      chk("hi_duty", evq[k].duty, 15);
      chk("hi_period", evq[k].per, 32);
      chk("hi_stuck", evq[k].stuck, 1);
      chk("hi_perr", evq[k].err, 1);
      chk("hi_locked", evq[k].lock, 0);
    end

    // ---------------- stuck low: no rise, first timeout after 32 ticks ----------------
    do_reset();
    repeat (100) step(1'b0, 1'b1, 1'b0);
    chk("lo_count", evq.size(), 3);
    foreach (evq[k]) begin
      chk("lo_tick", evq[k].t, 32 + 32*k);
      chk("lo_duty", evq[k].duty, 0);
      chk("lo_period", evq[k].per, 32);
      chk("lo_stuck", evq[k].stuck, 1);
      chk("lo_locked", evq[k].lock, 0);
    end

    // ---------------- reset mid-period while locked ----------------
    do_reset();
    run_wave(16, 9, 2, 0);
    for (int t = 0; t < 12; t++) step(t < 9, 1'b1, 1'b0);
    chk("mid_locked_before", lock, 1);
    chk("mid_valids_before", evq.size(), 2);
    step(1'b0, 1'b1, 1'b1);
    evq.delete();
    step(1'b0, 1'b1, 1'b0);
    chk("mid_rst_valid", vld, 0);
    chk("mid_rst_duty", duty, 0);
    chk("mid_rst_period", per, 0);
    chk("mid_rst_stuck", stuck, 0);
    chk("mid_rst_perr", perr, 0);
    chk("mid_rst_locked", lock, 0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_wave(16, 9, 1, 5);
    chk("mid_after_count", evq.size(), 1);
    foreach (evq[k]) begin
      chk("mid_after_duty", evq[k].duty, 8);
      chk("mid_after_period", evq[k].per, 16);
      chk("mid_after_perr", evq[k].err, 0);
      chk("mid_after_locked", evq[k].lock, 1);
    end

    // ---------------- enable strobed 1-in-4, duty 3 ----------------
    do_reset();
    for (int m = 0; m < 67; m++)
      for (int c = 0; c < 4; c++) step((m % 16) < 4, c == 3, 1'b0);
    chk("strobe_count", evq.size(), 4);
    foreach (evq[k]) begin
      chk("strobe_duty", evq[k].duty, 3);
      chk("strobe_period", evq[k].per, 16);
      chk("strobe_perr", evq[k].err, 0);
      chk("strobe_after_enable", evq[k].en_prev, 1);
      if (k > 0) chk("strobe_spacing", evq[k].t - evq[k-1].t, 64);
    end

    // ---------------- random waveforms vs. window model ----------------
    begin
      int b, hi, seg, p, h, reps, len;
      bit armed, sp, sj;
      int e_v, e_d, e_p, e_s, e_e, e_l;
      pq.delete();
      while (pq.size() < 1500) begin
        seg = $urandom_range(0, 9);
        if (seg == 0) begin
          sj  = 1'($urandom_range(0, 1));
          len = $urandom_range(40, 80);
          for (int t = 0; t < len; t++) pq.push_back(sj);
        end else begin
          p    = (seg < 6) ? 16 : $urandom_range(3, 24);
          h    = $urandom_range(1, p - 1);
          reps = $urandom_range(1, 4);
          for (int r = 0; r < reps; r++)
            for (int t = 0; t < p; t++) pq.push_back(t < h);
        end
      end
      do_reset();
      b = 0; armed = 0; sp = 0;
      e_v = 0; e_d = 0; e_p = 0; e_s = 0; e_e = 0; e_l = 0;
      for (int j = 0; j < pq.size(); j++) begin
        step(pq[j], 1'b1, 1'b0);
        chk("rnd_valid", vld, e_v);
        chk("rnd_locked", lock, e_l);
        chk("rnd_duty", duty, e_d);
        chk("rnd_period", per, e_p);
        chk("rnd_stuck", stuck, e_s);
        chk("rnd_perr", perr, e_e);
        // Outcome of tick j, visible on tick j+1. Window [b, j) is the current period.
        sj = samp_at(j);
        e_v = 0;
        if (sj && !sp) begin
          if (armed) begin
            hi = 0;
            for (int k = b; k < j; k++) hi += samp_at(k);
            e_v = 1;
            e_p = j - b;
            e_d = (hi == 0) ? 0 : ((hi - 1 > 15) ? 15 : hi - 1);
            e_s = 0;
            e_e = ((j - b) != CTRVAL) ? 1 : 0;
          end
          armed = 1;
          b = j;
        end else if (j - b == 2*CTRVAL - 1) begin
          e_v = 1; e_p = 2*CTRVAL; e_d = sj ? 15 : 0; e_s = 1; e_e = 1;
          armed = 0;
          b = j + 1;
        end
        e_l = armed;
        sp = sj;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
